// File: rtl/vga_csync_gen_if.sv
// Sync bundle between the video timing source and the composite sync generator.
interface vga_csync_gen_if;
  logic hsync_in;
  logic vsync_in;
  logic hsync;
  logic vsync;
  logic csync;
  logic lock;

  modport master (output hsync_in, vsync_in, input hsync, vsync, csync, lock);
  modport slave  (input hsync_in, vsync_in, output hsync, vsync, csync, lock);
endinterface

// File: rtl/vga_csync_gen.sv
// Composite sync generator with line/hsync-width measurement and vsync serration.
// Two-clock latency from hsync_in/vsync_in to hsync/vsync/csync.
module vga_csync_gen #(
  parameter int       CW      = 12,
  parameter logic     HS_POL  = 1'b0,
  parameter logic     VS_POL  = 1'b0,
  parameter int       SERR_EN = 1
) (
  input logic            clk,
  input logic            reset,
  vga_csync_gen_if.slave bus
);

  localparam logic [CW-1:0] CMAX = '1;

  logic          hs, vs;
  logic [CW-1:0] hcnt, hcnt_nxt;
  logic [CW-1:0] line_len, hs_width;
  logic          seen, valid;
  logic          hs_n, vs_n, rise, fall, sat;
  logic [CW+1:0] len_new, min_len;
  logic          len_ok;
  logic          cs;
  logic          hsync_q, vsync_q, csync_q;

  // Edges are detected against the incoming sample so hcnt is 0 in the
  // same stage-1 cycle where hs first reads high.
  assign hs_n = (bus.hsync_in == HS_POL);
  assign vs_n = (bus.vsync_in == VS_POL);
  assign rise = hs_n & ~hs;
  assign fall = ~hs_n & hs;
  assign sat  = (hcnt == CMAX);

  assign len_new = {2'b00, hcnt} + 1'b1;
  assign min_len = {1'b0, hs_width, 1'b0} + 2'd2;
  assign len_ok  = (len_new >= min_len);

  always_comb begin
    hcnt_nxt = hcnt + 1'b1;
    if (rise)
      hcnt_nxt = '0;
    else if (sat)
      hcnt_nxt = hcnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs       <= 1'b0;
      vs       <= 1'b0;
      hcnt     <= '0;
      line_len <= '0;
      hs_width <= '0;
      seen     <= 1'b0;
      valid    <= 1'b0;
    end else begin
      hs   <= hs_n;
      vs   <= vs_n;
      hcnt <= hcnt_nxt;
      if (fall && !sat)
        hs_width <= hcnt + 1'b1;
      if (rise) begin
        seen <= 1'b1;
        if (!sat) begin
          line_len <= hcnt + 1'b1;
          if (seen)
            valid <= len_ok;
        end
      end else if (hcnt_nxt == CMAX) begin
        seen  <= 1'b0;
        valid <= 1'b0;
      end
    end
  end

  // Serration gap is the last hs_width clocks of the line; the add form
  // avoids underflow while line_len/hs_width are mid-update.
  always_comb begin
    cs = hs | vs;
    if ((SERR_EN != 0) && valid && vs)
      cs = (({1'b0, hcnt} + {1'b0, hs_width}) < {1'b0, line_len});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      csync_q <= 1'b1;
    end else begin
      hsync_q <= ~hs;
      vsync_q <= ~vs;
      csync_q <= ~cs;
    end
  end

  assign bus.hsync = hsync_q;
  assign bus.vsync = vsync_q;
  assign bus.csync = csync_q;
  assign bus.lock  = valid;

endmodule

// File: tb/tb_vga_csync_gen.sv
// Bench: serrated and plain-OR instances driven together, checked every cycle against an edge-index model.
module tb_vga_csync_gen;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  vga_csync_gen_if vif1 ();
  vga_csync_gen_if vif0 ();

  vga_csync_gen #(.CW(12), .HS_POL(1'b0), .VS_POL(1'b0), .SERR_EN(1)) dut1 (
    .clk(clk), .reset(rst), .bus(vif1.slave));
  vga_csync_gen #(.CW(12), .HS_POL(1'b0), .VS_POL(1'b0), .SERR_EN(0)) dut0 (
    .clk(clk), .reset(rst), .bus(vif0.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
    end
  endtask

  // Model: time is an edge index; hcnt is clocks since the last hs leading edge.
  int m_e, m_last_rise, m_line, m_width;
  bit m_seen, m_valid, m_hs, m_vs;
  bit x_hsync, x_vsync, x_cs1, x_cs0;

  function automatic bit model_cs(input bit serr);
    int h;
    h = m_e - m_last_rise;
    if (h > 4095) h = 4095;
    if (serr && m_valid && m_vs) return (h + m_width) < m_line;
    return m_hs | m_vs;
  endfunction

  always @(posedge clk) begin
    bit in_hs, in_vs, rise, fall;
    int el;
    if (rst) begin
      m_e = 0; m_last_rise = 0; m_line = 0; m_width = 0;
      m_seen = 0; m_valid = 0; m_hs = 0; m_vs = 0;
      x_hsync = 1; x_vsync = 1; x_cs1 = 1; x_cs0 = 1;
    end else begin
      x_hsync = !m_hs;
      x_vsync = !m_vs;
      x_cs1   = !model_cs(1'b1);
      x_cs0   = !model_cs(1'b0);
      in_hs = (vif1.hsync_in == 1'b0);
      in_vs = (vif1.vsync_in == 1'b0);
      m_e++;
      rise = in_hs && !m_hs;
      fall = !in_hs && m_hs;
      el   = m_e - m_last_rise;
      if (fall && el <= 4095) m_width = el;
      if (rise) begin
        if (el <= 4095) begin
          m_line = el;
          if (m_seen) m_valid = (el >= 2 * m_width + 2);
        end
        m_seen = 1;
        m_last_rise = m_e;
      end else if (el >= 4095) begin
        m_seen = 0;
        m_valid = 0;
      end
      m_hs = in_hs;
      m_vs = in_vs;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("hsync",  vif1.hsync, x_hsync);
      chk("vsync",  vif1.vsync, x_vsync);
      chk("csync",  vif1.csync, x_cs1);
      chk("lock",   vif1.lock,  m_valid);
      chk("csync0", vif0.csync, x_cs0);
      chk("lock0",  vif0.lock,  m_valid);
    end
  end

  task automatic drive(input bit h_act, input bit v_act);
    vif1.hsync_in = !h_act;
    vif0.hsync_in = !h_act;
    vif1.vsync_in = !v_act;
    vif0.vsync_in = !v_act;
  endtask

  // One line: hs active for w clocks, period p; returns csync-high counts seen during it.
  task automatic line(input int p, input int w, input bit v, output int hi1, output int hi0);
    hi1 = 0;
    hi0 = 0;
    for (int k = 0; k < p; k++) begin
      @(negedge clk);
      hi1 += vif1.csync;
      hi0 += vif0.csync;
      drive(k < w, v);
    end
  endtask

  initial begin
    int h1, h0, p, w;
    bit v;
    total = 0;
    bad = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_hsync", vif1.hsync, 1);
    chk("rst_vsync", vif1.vsync, 1);
    chk("rst_csync", vif1.csync, 1);
    chk("rst_lock",  vif1.lock,  0);
    @(negedge clk);
    rst = 1'b0;

    // Basic lock on 100/10 lines
    line(100, 10, 0, h1, h0);
    chk("lock_after_1", vif1.lock, 0);
    repeat (3) line(100, 10, 0, h1, h0);
    chk("lock_100", vif1.lock, 1);
    chk("model_line_100", m_line, 100);
    chk("model_width_10", m_width, 10);

    // Serration across vsync lines
    line(100, 10, 1, h1, h0);
    line(100, 10, 1, h1, h0);
    chk("serr_gap_100", h1, 10);
    chk("plain_or_gap", h0, 0);
    line(100, 10, 1, h1, h0);
    repeat (2) line(100, 10, 0, h1, h0);

    // Too-short line fails the minimum check, then recovers
    repeat (3) line(20, 10, 0, h1, h0);
    chk("lock_short", vif1.lock, 0);
    repeat (3) line(100, 10, 0, h1, h0);
    chk("lock_recover", vif1.lock, 1);

    // Saturation: hsync idle long enough to pin hcnt
    repeat (5000) begin
      @(negedge clk);
      drive(1'b0, 1'b0);
    end
    chk("lock_sat", vif1.lock, 0);
    line(100, 10, 0, h1, h0);
    chk("lock_sat_1line", vif1.lock, 0);
    repeat (2) line(100, 10, 0, h1, h0);
    chk("lock_sat_back", vif1.lock, 1);

    // Line-length change 100 -> 120
    line(120, 10, 0, h1, h0);
    chk("lock_switch", vif1.lock, 1);
    repeat (2) line(120, 10, 0, h1, h0);
    chk("model_line_120", m_line, 120);
    line(120, 10, 1, h1, h0);
    line(120, 10, 1, h1, h0);
    chk("serr_gap_120", h1, 10);
    line(120, 10, 1, h1, h0);

    // Randomized line timing and vsync bursts
    for (int n = 0; n < 40; n++) begin
      p = $urandom_range(150, 30);
      w = $urandom_range(20, 2);
      v = ($urandom_range(3, 0) == 0);
      repeat ($urandom_range(3, 1)) line(p, w, v, h1, h0);
    end

    // Asynchronous reset mid-vsync
    repeat (3) line(100, 10, 1, h1, h0);
    chk("lock_pre_rst", vif1.lock, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_hsync", vif1.hsync, 1);
    chk("arst_vsync", vif1.vsync, 1);
    chk("arst_csync", vif1.csync, 1);
    chk("arst_lock",  vif1.lock,  0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    line(100, 10, 1, h1, h0);
    chk("lock_post_rst_1", vif1.lock, 0);
    line(100, 10, 1, h1, h0);
    line(100, 10, 1, h1, h0);
    chk("lock_post_rst", vif1.lock, 1);
    line(100, 10, 1, h1, h0);
    chk("serr_post_rst", h1, 10);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
